// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the sequencer's control inputs and fetch outputs so the
//   sequencer and its environment connect through one port.
//   master : drives en, stall, br_instr, br_target, branch_sel, prog_last;
//            observes pc, pc_valid, flush, wrap
//   slave  : the sequencer side (opposite directions)
//   en          run enable; 0 parks the sequencer in IDLE
//   stall       freeze PC and state (the branch decision is still captured)
//   br_instr    decode issued a branch this cycle
//   br_target   branch target, valid with br_instr
//   branch_sel  branch unit decision, valid one cycle after br_instr
//   prog_last   address of the last instruction of the program
//   pc          fetch address
//   pc_valid    pc is a live fetch this cycle
//   flush       discard in-flight wrong-path instructions
//   wrap        one-cycle pulse when pc wrapped from prog_last to the reset PC
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 10
);
    logic                en;
    logic                stall;
    logic                br_instr;
    logic [PC_WIDTH-1:0] br_target;
    logic                branch_sel;
    logic [PC_WIDTH-1:0] prog_last;
    logic [PC_WIDTH-1:0] pc;
    logic                pc_valid;
    logic                flush;
    logic                wrap;

    modport master (
        output en, stall, br_instr, br_target, branch_sel, prog_last,
        input  pc, pc_valid, flush, wrap
    );

    modport slave (
        input  en, stall, br_instr, br_target, branch_sel, prog_last,
        output pc, pc_valid, flush, wrap
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the IPPro datapath. Issues sequential
//   fetch addresses, captures branch targets from decode, resolves them
//   with the branch unit decision one cycle later and redirects on a taken
//   branch while raising flush. Prediction is always not-taken.
// Ports
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    pc_sequencer_if slave modport (controls in, pc/pc_valid/flush/wrap out)
// Parameters
//   PC_WIDTH      width of pc and branch target
//   RESET_PC      pc after reset and on program wrap
//   FLUSH_CYCLES  cycles flush stays high after a taken branch (1..15)
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESOLVE
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc_q, pc_next;
    logic [PC_WIDTH-1:0] target_q, target_next;
    logic                pc_valid_q, pc_valid_next;
    logic                wrap_q, wrap_next;
    logic                dec_q, dec_next;
    logic                dec_pend, dec_pend_next;
    logic [3:0]          flush_cnt, flush_cnt_next;
    logic [PC_WIDTH-1:0] seq_pc;
    logic                seq_wrap;
    logic                flush;
    logic                decision;

    assign flush    = (flush_cnt != 4'd0);
    // A decision captured during a stall takes precedence over the live input.
    assign decision = dec_pend ? dec_q : bus.branch_sel;

    // Sequential successor of the current pc, wrapping at the program end.
    always_comb begin
        seq_pc   = pc_q + PC_WIDTH'(1);
        seq_wrap = 1'b0;
        if (pc_q == bus.prog_last) begin
            seq_pc   = RESET_PC;
            seq_wrap = 1'b1;
        end
    end

    // Next-state logic. Stall freezes everything except the first-cycle
    // capture of the branch decision and the flush countdown.
    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        target_next    = target_q;
        wrap_next      = 1'b0;
        dec_next       = dec_q;
        dec_pend_next  = dec_pend;
        flush_cnt_next = flush ? (flush_cnt - 4'd1) : 4'd0;

        case (state)
            IDLE: begin
                if (bus.en && !bus.stall) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    pc_next   = seq_pc;
                    wrap_next = seq_wrap;
                    // Branches seen while flushing are wrong-path and dropped.
                    if (bus.br_instr && !flush) begin
                        target_next = bus.br_target;
                        state_next  = RESOLVE;
                    end else if (!bus.en) begin
                        state_next = IDLE;
                    end
                end
            end
            RESOLVE: begin
                if (bus.stall) begin
                    // The branch unit does not stall, so hold its answer.
                    if (!dec_pend) begin
                        dec_next      = bus.branch_sel;
                        dec_pend_next = 1'b1;
                    end
                end else begin
                    dec_pend_next = 1'b0;
                    if (decision) begin
                        pc_next        = target_q;
                        flush_cnt_next = FLUSH_LOAD;
                        state_next     = bus.en ? RUN : IDLE;
                    end else begin
                        pc_next   = seq_pc;
                        wrap_next = seq_wrap;
                        if (bus.br_instr && !flush) begin
                            target_next = bus.br_target;
                            state_next  = RESOLVE;
                        end else begin
                            state_next = bus.en ? RUN : IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // pc_valid is aligned with the pc it qualifies.
        pc_valid_next = (state_next != IDLE) && !bus.stall;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            pc_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
            dec_q      <= 1'b0;
            dec_pend   <= 1'b0;
            flush_cnt  <= 4'd0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            target_q   <= target_next;
            pc_valid_q <= pc_valid_next;
            wrap_q     <= wrap_next;
            dec_q      <= dec_next;
            dec_pend   <= dec_pend_next;
            flush_cnt  <= flush_cnt_next;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.flush    = flush;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed testbench for pc_sequencer: reset, sequential run with wrap,
//   taken / not-taken / back-to-back branches, stall during resolve,
//   asynchronous reset mid-branch and enable drop/resume.
module tb_pc_sequencer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.PC_WIDTH(10)) bus ();

    pc_sequencer #(
        .PC_WIDTH(10),
        .RESET_PC(10'd0),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [9:0] last);
        bus.en         = 1'b0;
        bus.stall      = 1'b0;
        bus.br_instr   = 1'b0;
        bus.br_target  = '0;
        bus.branch_sel = 1'b0;
        bus.prog_last  = last;
        rst_n          = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Enable and advance until pc shows the requested address.
    task automatic run_to(input int n);
        bus.en = 1'b1;
        step();
        repeat (n) step();
    endtask

    task automatic test_reset();
        apply_reset(10'd5);
        checks++;
        if (bus.pc !== 10'd0 || bus.pc_valid !== 1'b0 || bus.flush !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got pc=%h valid=%b flush=%b wrap=%b exp pc=000 valid=0 flush=0 wrap=0",
                     bus.pc, bus.pc_valid, bus.flush, bus.wrap);
        end
        repeat (2) step();
        checks++;
        if (bus.pc !== 10'd0 || bus.pc_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold got pc=%h valid=%b exp pc=000 valid=0", bus.pc, bus.pc_valid);
        end
        bus.en = 1'b1;
        step();
        checks++;
        if (bus.pc !== 10'd0 || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_fetch got pc=%h valid=%b exp pc=000 valid=1", bus.pc, bus.pc_valid);
        end
    endtask

    task automatic test_sequential();
        logic [9:0] exp_pc [8] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd0, 10'd1};
        logic       exp_wr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset(10'd5);
        run_to(0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.pc !== exp_pc[i] || bus.wrap !== exp_wr[i] || bus.pc_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL seq[%0d] got pc=%h wrap=%b valid=%b exp pc=%h wrap=%b valid=1",
                         i, bus.pc, bus.wrap, bus.pc_valid, exp_pc[i], exp_wr[i]);
            end
            step();
        end
    endtask

    task automatic test_taken();
        logic [9:0] exp_pc [6] = '{10'h003, 10'h004, 10'h040, 10'h041, 10'h042, 10'h043};
        logic       exp_fl [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       br     [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       sel    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0] tgt    [6] = '{10'h040, 10'h000, 10'h080, 10'h000, 10'h000, 10'h000};
        apply_reset(10'h3FF);
        run_to(3);
        for (int i = 0; i < 6; i++) begin
            bus.br_instr   = br[i];
            bus.branch_sel = sel[i];
            bus.br_target  = tgt[i];
            checks++;
            if (bus.pc !== exp_pc[i] || bus.flush !== exp_fl[i] || bus.wrap !== 1'b0) begin
                errors++;
                $display("[TB] FAIL taken[%0d] got pc=%h flush=%b wrap=%b exp pc=%h flush=%b wrap=0",
                         i, bus.pc, bus.flush, bus.wrap, exp_pc[i], exp_fl[i]);
            end
            step();
        end
        bus.br_instr   = 1'b0;
        bus.branch_sel = 1'b0;
    endtask

    task automatic test_not_taken();
        logic [9:0] exp_pc [4] = '{10'h003, 10'h004, 10'h005, 10'h006};
        logic       br     [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset(10'h3FF);
        run_to(3);
        for (int i = 0; i < 4; i++) begin
            bus.br_instr   = br[i];
            bus.br_target  = 10'h040;
            bus.branch_sel = 1'b0;
            checks++;
            if (bus.pc !== exp_pc[i] || bus.flush !== 1'b0) begin
                errors++;
                $display("[TB] FAIL not_taken[%0d] got pc=%h flush=%b exp pc=%h flush=0",
                         i, bus.pc, bus.flush, exp_pc[i]);
            end
            step();
        end
        bus.br_instr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_pc [6] = '{10'h003, 10'h004, 10'h005, 10'h020, 10'h021, 10'h022};
        logic       exp_fl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       br     [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       sel    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [9:0] tgt    [6] = '{10'h040, 10'h020, 10'h000, 10'h000, 10'h000, 10'h000};
        apply_reset(10'h3FF);
        run_to(3);
        for (int i = 0; i < 6; i++) begin
            bus.br_instr   = br[i];
            bus.branch_sel = sel[i];
            bus.br_target  = tgt[i];
            checks++;
            if (bus.pc !== exp_pc[i] || bus.flush !== exp_fl[i]) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d] got pc=%h flush=%b exp pc=%h flush=%b",
                         i, bus.pc, bus.flush, exp_pc[i], exp_fl[i]);
            end
            step();
        end
        bus.br_instr   = 1'b0;
        bus.branch_sel = 1'b0;
    endtask

    task automatic test_stall();
        logic [9:0] exp_pc [7] = '{10'h003, 10'h004, 10'h004, 10'h004, 10'h004, 10'h040, 10'h041};
        logic       exp_vl [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_fl [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       br     [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       sel    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       stl    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset(10'h3FF);
        run_to(3);
        for (int i = 0; i < 7; i++) begin
            bus.br_instr   = br[i];
            bus.br_target  = 10'h040;
            bus.branch_sel = sel[i];
            bus.stall      = stl[i];
            checks++;
            if (bus.pc !== exp_pc[i] || bus.pc_valid !== exp_vl[i] || bus.flush !== exp_fl[i]) begin
                errors++;
                $display("[TB] FAIL stall[%0d] got pc=%h valid=%b flush=%b exp pc=%h valid=%b flush=%b",
                         i, bus.pc, bus.pc_valid, bus.flush, exp_pc[i], exp_vl[i], exp_fl[i]);
            end
            step();
        end
        bus.br_instr = 1'b0;
        bus.stall    = 1'b0;
    endtask

    task automatic test_reset_mid_branch();
        apply_reset(10'h3FF);
        run_to(3);
        bus.br_instr  = 1'b1;
        bus.br_target = 10'h00F;
        step();
        bus.br_instr   = 1'b0;
        bus.branch_sel = 1'b1;
        step();
        bus.branch_sel = 1'b0;
        repeat (2) step();
        bus.br_instr  = 1'b1;
        bus.br_target = 10'h030;
        step();
        bus.br_instr = 1'b0;
        checks++;
        if (bus.pc !== 10'h012 || bus.flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset got pc=%h flush=%b exp pc=012 flush=0", bus.pc, bus.flush);
        end
        bus.branch_sel = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 10'd0 || bus.pc_valid !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got pc=%h valid=%b flush=%b exp pc=000 valid=0 flush=0",
                     bus.pc, bus.pc_valid, bus.flush);
        end
        step();
        rst_n          = 1'b1;
        bus.branch_sel = 1'b0;
        step();
        checks++;
        if (bus.pc !== 10'd0 || bus.pc_valid !== 1'b1 || bus.flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart got pc=%h valid=%b flush=%b exp pc=000 valid=1 flush=0",
                     bus.pc, bus.pc_valid, bus.flush);
        end
        step();
        checks++;
        if (bus.pc !== 10'd1 || bus.flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_step got pc=%h flush=%b exp pc=001 flush=0", bus.pc, bus.flush);
        end
    endtask

    task automatic test_wrap_enable();
        logic [9:0] exp_pc [6] = '{10'h003, 10'h004, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        logic       exp_wr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       br     [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       sel    [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [9:0] hold_pc [4] = '{10'h008, 10'h008, 10'h008, 10'h009};
        logic       hold_vl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       hold_en [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset(10'h3FF);
        run_to(3);
        for (int i = 0; i < 6; i++) begin
            bus.br_instr   = br[i];
            bus.br_target  = 10'h3FD;
            bus.branch_sel = sel[i];
            checks++;
            if (bus.pc !== exp_pc[i] || bus.wrap !== exp_wr[i]) begin
                errors++;
                $display("[TB] FAIL wrap[%0d] got pc=%h wrap=%b exp pc=%h wrap=%b",
                         i, bus.pc, bus.wrap, exp_pc[i], exp_wr[i]);
            end
            step();
        end
        repeat (6) step();
        checks++;
        if (bus.pc !== 10'h007 || bus.pc_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL before_disable got pc=%h valid=%b exp pc=007 valid=1", bus.pc, bus.pc_valid);
        end
        bus.en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.pc !== hold_pc[i] || bus.pc_valid !== hold_vl[i]) begin
                errors++;
                $display("[TB] FAIL enable[%0d] got pc=%h valid=%b exp pc=%h valid=%b",
                         i, bus.pc, bus.pc_valid, hold_pc[i], hold_vl[i]);
            end
            bus.en = hold_en[i];
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_sequential();
        test_taken();
        test_not_taken();
        test_back_to_back();
        test_stall();
        test_reset_mid_branch();
        test_wrap_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] timeout");
    end
endmodule
